// File: rtl/ex_muldiv_seq_pkg.sv
// Shared constants and types for the RV32M multiply/divide sequencer.
package ex_muldiv_seq_pkg;
  localparam int MD_XLEN = 32;

  typedef enum logic [2:0] {
    MDOP_MUL    = 3'd0,
    MDOP_MULH   = 3'd1,
    MDOP_MULHSU = 3'd2,
    MDOP_MULHU  = 3'd3,
    MDOP_DIV    = 3'd4,
    MDOP_DIVU   = 3'd5,
    MDOP_REM    = 3'd6,
    MDOP_REMU   = 3'd7
  } mdop_e;

  typedef enum logic [1:0] {
    MDST_IDLE = 2'd0,
    MDST_CALC = 2'd1,
    MDST_FIX  = 2'd2,
    MDST_DONE = 2'd3
  } mdst_e;

  function automatic logic mdop_is_div(mdop_e op);
    return op[2];
  endfunction
endpackage

// File: rtl/ex_muldiv_seq_if.sv
// Execute-stage handshake between decode/mem control and the muldiv sequencer.
interface ex_muldiv_seq_if;
  import ex_muldiv_seq_pkg::*;
  logic               md_start;
  logic [2:0]         md_op;
  logic [MD_XLEN-1:0] md_rs1;
  logic [MD_XLEN-1:0] md_rs2;
  logic               md_kill;
  logic               mem_stall;
  logic               md_busy;
  logic               md_done;
  logic [MD_XLEN-1:0] md_result;

  modport master (
    output md_start, md_op, md_rs1, md_rs2, md_kill, mem_stall,
    input  md_busy, md_done, md_result
  );
  modport slave (
    input  md_start, md_op, md_rs1, md_rs2, md_kill, mem_stall,
    output md_busy, md_done, md_result
  );
endinterface

// File: rtl/muldiv_iter.sv
// Shared shift-add / restoring shift-subtract step on a 64-bit {hi, lo} register.
module muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  logic [XLEN-1:0] b_q;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   part;
  logic [XLEN:0]   diff;
  logic            ge;

  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
  assign part = {hi, lo[XLEN-1]};
  assign diff = part - {1'b0, b_q};
  // A set top bit in part means part already exceeds any 32-bit divisor.
  assign ge   = part[XLEN] | ~diff[XLEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi  <= '0;
      lo  <= '0;
      b_q <= '0;
    end else if (init) begin
      hi  <= '0;
      lo  <= op_a;
      b_q <= op_b;
    end else if (step) begin
      if (is_div) begin
        hi <= ge ? diff[XLEN-1:0] : part[XLEN-1:0];
        lo <= {lo[XLEN-2:0], ge};
      end else begin
        hi <= sum[XLEN:1];
        lo <= {sum[0], lo[XLEN-1:1]};
      end
    end
  end
endmodule

// File: rtl/ex_muldiv_seq.sv
// RV32M multiply/divide sequencer: FSM, counter, sign handling and div fast path.
module ex_muldiv_seq
  import ex_muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clk,
  input logic reset,
  ex_muldiv_seq_if.slave md
);
  mdst_e           state;
  mdop_e           op_q;
  logic [4:0]      count;
  logic            neg_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] hi, lo;

  mdop_e           op_in;
  logic            a_neg, b_neg, neg_in;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;
  logic            accept;

  assign op_in  = mdop_e'(md.md_op);
  assign a_neg  = (op_in inside {MDOP_MULH, MDOP_MULHSU, MDOP_DIV, MDOP_REM}) & md.md_rs1[XLEN-1];
  assign b_neg  = (op_in inside {MDOP_MULH, MDOP_DIV, MDOP_REM}) & md.md_rs2[XLEN-1];
  assign a_abs  = a_neg ? -md.md_rs1 : md.md_rs1;
  assign b_abs  = b_neg ? -md.md_rs2 : md.md_rs2;
  assign neg_in = (op_in == MDOP_REM) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = mdop_is_div(op_in) & (md.md_rs2 == '0);
  assign div_ovf  = (op_in inside {MDOP_DIV, MDOP_REM}) &
                    (md.md_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (md.md_rs2 == '1);
  assign fast     = div_zero | div_ovf;
  // Overflow DIV returns rs1 itself (the most negative value); REM returns 0.
  assign fast_res = div_zero ? ((op_in inside {MDOP_DIV, MDOP_DIVU}) ? '1 : md.md_rs1)
                             : ((op_in == MDOP_DIV) ? md.md_rs1 : '0);
  assign accept   = (state == MDST_IDLE) & md.md_start & ~md.md_kill;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .init   (accept & ~fast),
    .step   (state == MDST_CALC),
    .is_div (mdop_is_div(op_q)),
    .op_a   (a_abs),
    .op_b   (b_abs),
    .hi     (hi),
    .lo     (lo)
  );

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_sel, div_s, fix_res;

  assign prod_s  = neg_q ? -{hi, lo} : {hi, lo};
  assign div_sel = (op_q inside {MDOP_DIV, MDOP_DIVU}) ? lo : hi;
  assign div_s   = neg_q ? -div_sel : div_sel;
  assign fix_res = mdop_is_div(op_q) ? div_s :
                   (op_q == MDOP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= MDST_IDLE;
      op_q     <= MDOP_MUL;
      count    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (md.md_kill) begin
      state  <= MDST_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        MDST_IDLE: if (md.md_start) begin
          op_q  <= op_in;
          neg_q <= neg_in;
          count <= '0;
          if (fast) begin
            result_q <= fast_res;
            done_q   <= 1'b1;
            state    <= MDST_DONE;
          end else begin
            state <= MDST_CALC;
          end
        end
        MDST_CALC: begin
          count <= count + 5'd1;
          if (count == 5'd31) state <= MDST_FIX;
        end
        MDST_FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state    <= MDST_DONE;
        end
        MDST_DONE: if (!md.mem_stall) begin
          done_q <= 1'b0;
          state  <= MDST_IDLE;
        end
      endcase
    end
  end

  assign md.md_busy   = ((state == MDST_IDLE) & md.md_start) | (state == MDST_CALC) |
                        (state == MDST_FIX) | ((state == MDST_DONE) & md.mem_stall);
  assign md.md_done   = done_q;
  assign md.md_result = result_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Randomized bench for ex_muldiv_seq against an arithmetic reference and a cycle-count model.
module tb_ex_muldiv_seq;
  logic clk;
  logic reset;
  ex_muldiv_seq_if md_if();

  ex_muldiv_seq #(.XLEN(32)) dut (.clk(clk), .reset(reset), .md(md_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Cycle model: 0 idle, 1 computing (m_left edges to go), 2 result presented.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [31:0] m_res   = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) m_phase = 0;
    else if (md_if.md_kill) m_phase = 0;
    else begin
      case (m_phase)
        0: if (md_if.md_start) begin
          m_res   = ref_md(md_if.md_op, md_if.md_rs1, md_if.md_rs2);
          m_phase = is_fast(md_if.md_op, md_if.md_rs1, md_if.md_rs2) ? 2 : 1;
          m_left  = 33;
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (!md_if.mem_stall) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic eb;
    eb = (m_phase == 0 && md_if.md_start) || m_phase == 1 || (m_phase == 2 && md_if.mem_stall);
    chk("busy", {31'd0, md_if.md_busy}, {31'd0, eb});
    chk("done", {31'd0, md_if.md_done}, {31'd0, m_phase == 2});
    if (m_phase == 2) chk("result", md_if.md_result, m_res);
  end

  // Called #1 after an edge with the DUT idle; returns #1 after the edge that consumed the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_stall, input bit rnd_stall,
                        output logic [31:0] res, output int lat);
    md_if.md_start = 1'b1;
    md_if.md_op    = op;
    md_if.md_rs1   = a;
    md_if.md_rs2   = b;
    @(posedge clk); #1;
    md_if.md_start = 1'b0;
    md_if.md_op    = 3'($urandom);
    md_if.md_rs1   = $urandom;
    md_if.md_rs2   = $urandom;
    lat = 1;
    while (!md_if.md_done && lat < 60) begin
      md_if.mem_stall = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res = md_if.md_result;
    if (!md_if.md_done) begin
      checks++;
      errors++;
      $display("FAIL timeout: md_done not seen after %0d cycles", lat);
      md_if.md_kill = 1'b1;
      @(posedge clk); #1;
      md_if.md_kill = 1'b0;
    end else begin
      md_if.mem_stall = (n_stall > 0);
      repeat (n_stall) begin @(posedge clk); #1; end
      md_if.mem_stall = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_kill(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int k);
    md_if.md_start  = 1'b1;
    md_if.md_op     = op;
    md_if.md_rs1    = a;
    md_if.md_rs2    = b;
    md_if.mem_stall = 1'b1;
    @(posedge clk); #1;
    md_if.md_start = 1'b0;
    repeat (k) begin @(posedge clk); #1; end
    md_if.md_kill = 1'b1;
    @(posedge clk); #1;
    md_if.md_kill   = 1'b0;
    md_if.mem_stall = 1'b0;
    chk("kill_done", {31'd0, md_if.md_done}, 32'd0);
    chk("kill_busy", {31'd0, md_if.md_busy}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } dir_t;

  dir_t dir_tbl[$] = '{
    '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34},
    '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34},
    '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34},
    '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34},
    '{3'd5, 32'd100,        32'd7,        32'd14,       34},
    '{3'd7, 32'd100,        32'd7,        32'd2,        34},
    '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 1},
    '{3'd6, 32'd5,          32'd0,        32'd5,        1},
    '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1}
  };

  initial begin
    logic [31:0] res;
    int          lat;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset           = 1'b1;
    md_if.md_start  = 1'b0;
    md_if.md_op     = '0;
    md_if.md_rs1    = '0;
    md_if.md_rs2    = '0;
    md_if.md_kill   = 1'b0;
    md_if.mem_stall = 1'b0;

    foreach (dir_tbl[i])
      chk($sformatf("ref_pin%0d", i), ref_md(dir_tbl[i].op, dir_tbl[i].a, dir_tbl[i].b), dir_tbl[i].exp);
    chk("ref_pin_mulhsu", ref_md(3'd2, 32'hFFFFFFFF, 32'd2), 32'hFFFFFFFF);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",   {31'd0, md_if.md_done}, 32'd0);
    chk("rst_result", md_if.md_result, 32'd0);
    chk("rst_busy",   {31'd0, md_if.md_busy}, 32'd0);
    md_if.md_start = 1'b1;
    #1;
    chk("rst_busy_start", {31'd0, md_if.md_busy}, 32'd1);
    md_if.md_start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (dir_tbl[i]) begin
      run_op(dir_tbl[i].op, dir_tbl[i].a, dir_tbl[i].b, 0, 1'b0, res, lat);
      chk($sformatf("dir%0d_res", i), res, dir_tbl[i].exp);
      chk($sformatf("dir%0d_lat", i), 32'(lat), 32'(dir_tbl[i].lat));
    end

    // Result held through a 3-cycle downstream stall.
    run_op(3'd5, 32'd100, 32'd7, 3, 1'b0, res, lat);
    chk("stall_res", res, 32'd14);
    chk("stall_idle_done", {31'd0, md_if.md_done}, 32'd0);

    run_kill(3'd0, 32'h12345678, 32'h9ABCDEF0, 10);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2, 0, 1'b0, res, lat);
    chk("after_kill_res", res, 32'hFFFFFFFF);
    chk("after_kill_lat", 32'(lat), 32'd34);

    // Asynchronous reset at CALC count 20.
    md_if.md_start = 1'b1;
    md_if.md_op    = 3'd1;
    md_if.md_rs1   = 32'hDEADBEEF;
    md_if.md_rs2   = 32'h00C0FFEE;
    @(posedge clk); #1;
    md_if.md_start = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("arst_done",   {31'd0, md_if.md_done}, 32'd0);
    chk("arst_result", md_if.md_result, 32'd0);
    chk("arst_busy",   {31'd0, md_if.md_busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op(3'd4, 32'hFFFFFF9C, 32'd7, 0, 1'b0, res, lat);
    chk("after_rst_res", res, 32'hFFFFFFF2);

    for (int n = 0; n < 80; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 7) == 0) begin
        run_kill(op, a, b, $urandom_range(0, 34));
      end else begin
        run_op(op, a, b, $urandom_range(0, 3), 1'b1, res, lat);
        chk("rnd_res", res, ref_md(op, a, b));
        chk("rnd_lat", 32'(lat), is_fast(op, a, b) ? 32'd1 : 32'd34);
      end
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
